// File: rtl/adc_merge_pkg.sv
// Shared sizing helpers and types for the ADC FIFO merge block.
package adc_merge_pkg;

    localparam int MAX_CHW = 3;

    typedef logic [MAX_CHW-1:0] chan_tag_t;

    function automatic int chw_f(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/adc_chan_fifo.sv
// One channel FIFO: circular buffer, wrapping pointers and occupancy count.
module adc_chan_fifo
    import adc_merge_pkg::*;
#(
    parameter int DW     = 32,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = 12,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = lvl_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          almost_full
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] count;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign rdata       = mem[rptr];
    assign full        = (count == LW'(DEPTH));
    assign empty       = (count == '0);
    assign level       = count;
    assign almost_full = (count >= LW'(AF_LVL));

endmodule

// File: rtl/adc_fifo_merge.sv
// Merges NCH ADC write channels into one tagged stream via round-robin.
module adc_fifo_merge
    import adc_merge_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int DW     = 32,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = 12,
    localparam int CHW   = chw_f(NCH),
    localparam int LW    = lvl_w(DEPTH)
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              write_en_export,
    input  logic [NCH*DW-1:0] fifo_in_writedata,
    input  logic [NCH-1:0]    fifo_in_write,
    output logic [NCH-1:0]    fifo_in_waitrequest,
    output logic [CHW+DW-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*LW-1:0] ch_level,
    output logic [NCH-1:0]    almost_full
);

    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [DW-1:0]  rdata [NCH];
    logic [CHW-1:0] last;
    logic [CHW-1:0] grant;
    logic [CHW:0]   sum;
    logic           found;
    logic           load;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign push[c] = fifo_in_write[c] & ~full[c]
                       & write_en_export & ~reset_reset;

        adc_chan_fifo #(
            .DW     (DW),
            .DEPTH  (DEPTH),
            .AF_LVL (AF_LVL)
        ) u_fifo (
            .clk         (clk_clk),
            .rst         (reset_reset),
            .push        (push[c]),
            .pop         (pop[c]),
            .wdata       (fifo_in_writedata[c*DW +: DW]),
            .rdata       (rdata[c]),
            .full        (full[c]),
            .empty       (empty[c]),
            .level       (ch_level[c*LW +: LW]),
            .almost_full (almost_full[c])
        );
    end

    assign fifo_in_waitrequest = full;
    assign load = ~out_valid | out_ready;

    // Search starts one past the last grant; sum < 2*NCH so one wrap suffices.
    always_comb begin
        found = 1'b0;
        grant = '0;
        sum   = '0;
        for (int i = 1; i <= NCH; i++) begin
            sum = {1'b0, last} + (CHW+1)'(i);
            if (sum >= (CHW+1)'(NCH)) sum = sum - (CHW+1)'(NCH);
            if (!found && !empty[sum[CHW-1:0]]) begin
                found = 1'b1;
                grant = sum[CHW-1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        if (load && found && !reset_reset) pop[grant] = 1'b1;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            last      <= CHW'(NCH - 1);
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data <= {grant, rdata[grant]};
                last     <= grant;
            end
        end
    end

endmodule

// File: tb/tb_adc_fifo_merge.sv
// Scoreboard bench for adc_fifo_merge with NCH=2, DW=32, DEPTH=16.
module tb_adc_fifo_merge;

    localparam int NCH = 2;
    localparam int DW  = 32;
    localparam int LW  = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              write_en_export = 1'b1;
    logic [NCH*DW-1:0] fifo_in_writedata = '0;
    logic [NCH-1:0]    fifo_in_write = '0;
    logic [NCH-1:0]    fifo_in_waitrequest;
    logic [DW:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NCH*LW-1:0] ch_level;
    logic [NCH-1:0]    almost_full;

    int checks = 0;
    int failures = 0;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    bit          tag_q [$];

    bit          prev_stall = 0;
    logic [DW:0] prev_data = '0;

    adc_fifo_merge #(
        .NCH (2), .DW (32), .DEPTH (16), .AF_LVL (12)
    ) dut (
        .clk_clk             (clk),
        .reset_reset         (reset),
        .write_en_export     (write_en_export),
        .fifo_in_writedata   (fifo_in_writedata),
        .fifo_in_write       (fifo_in_write),
        .fifo_in_waitrequest (fifo_in_waitrequest),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .ch_level            (ch_level),
        .almost_full         (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted output word.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (out_data[DW] == 1'b0) begin
                    if (q0.size() == 0) chk("unexpected_ch0", 64'd1, 64'd0);
                    else chk("data_ch0", 64'(out_data[DW-1:0]),
                             64'(q0.pop_front()));
                end else begin
                    if (q1.size() == 0) chk("unexpected_ch1", 64'd1, 64'd0);
                    else chk("data_ch1", 64'(out_data[DW-1:0]),
                             64'(q1.pop_front()));
                end
                if (tag_q.size() > 0)
                    chk("rr_tag", 64'(out_data[DW]), 64'(tag_q.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic write_word(input int ch, input logic [31:0] d,
                              input bit en);
        int n = 0;
        write_en_export = en;
        fifo_in_writedata[ch*DW +: DW] = d;
        fifo_in_write[ch] = 1'b1;
        while (fifo_in_waitrequest[ch] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            chk("write_timeout", 64'd1, 64'd0);
        end else begin
            if (en) begin
                if (ch == 0) q0.push_back(d);
                else q1.push_back(d);
            end
            @(posedge clk); #1;
        end
        fifo_in_write[ch] = 1'b0;
        write_en_export = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((q0.size() > 0 || q1.size() > 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        chk("drain_pending", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    task automatic latency(input int ch, input logic [31:0] d);
        logic [DW:0] e;
        e = {ch[0], d};
        write_word(ch, d, 1'b1);
        @(negedge clk);
        chk("lat_k1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_k2_valid", 64'(out_valid), 64'd1);
        chk("lat_k2_data", 64'(out_data), 64'(e));
        @(negedge clk);
        chk("lat_k3_valid", 64'(out_valid), 64'd0);
    endtask

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_wait", 64'(fifo_in_waitrequest), 64'd0);
        chk("rst_level", 64'(ch_level), 64'd0);
        chk("rst_af", 64'(almost_full), 64'd0);

        // single word latency
        @(posedge clk); #1;
        out_ready = 1'b1;
        latency(0, 32'hA000_0001);

        // acquisition disabled: words discarded
        for (int i = 0; i < 5; i++) begin
            write_word(0, 32'hD000_0000 + i, 1'b0);
            chk("dis_wait", 64'(fifo_in_waitrequest[0]), 64'd0);
            chk("dis_level", 64'(ch_level[LW-1:0]), 64'd0);
            chk("dis_valid", 64'(out_valid), 64'd0);
        end

        // fill ch1 while the output register holds a ch0 word
        out_ready = 1'b0;
        write_word(0, 32'hB000_00FF, 1'b1);
        for (int i = 0; i < 16; i++) begin
            write_word(1, 32'hB000_0000 + i, 1'b1);
            chk("fill_level", 64'(ch_level[2*LW-1:LW]), 64'(i + 1));
            chk("fill_af", 64'(almost_full[1]), 64'(i + 1 >= 12));
            chk("fill_wait", 64'(fifo_in_waitrequest[1]), 64'(i + 1 == 16));
        end
        fork
            write_word(1, 32'hB000_0010, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_wait", 64'(fifo_in_waitrequest[1]), 64'd1);
                    chk("full_level", 64'(ch_level[2*LW-1:LW]), 64'd16);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // round-robin alternation over preloaded channels
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) tag_q.push_back(i[0]);
        for (int i = 0; i < 4; i++) write_word(0, 32'hE000_0000 + i, 1'b1);
        for (int i = 0; i < 4; i++) write_word(1, 32'hE100_0000 + i, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_b2b_valid", 64'(out_valid), 64'd1);
        end
        drain();
        chk("rr_tags_left", 64'(tag_q.size()), 64'd0);

        // streaming with out_ready toggling 1,0,0,1
        fork
            for (int i = 0; i < 20; i++)
                write_word(i % 2, 32'hC000_0000 + i, 1'b1);
            for (int n = 0; n < 60; n++) begin
                out_ready = pat[n % 4];
                @(posedge clk); #1;
            end
        join
        drain();

        // reset with buffered words and a held output
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(0, 32'hF000_0000 + i, 1'b1);
        for (int i = 0; i < 3; i++) write_word(1, 32'hF100_0000 + i, 1'b1);
        @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        fifo_in_writedata[DW-1:0] = 32'h5555_AAAA;
        fifo_in_write[0] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        fifo_in_write[0] = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_level", 64'(ch_level), 64'd0);
        chk("mid_rst_af", 64'(almost_full), 64'd0);
        chk("mid_rst_wait", 64'(fifo_in_waitrequest), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        latency(1, 32'h1234_5678);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_fifo_merge.md
ADC_FIFO_MERGE -- requirements
Module: adc_fifo_merge

Parameters
REQ-001 NCH, default 2: number of ADC write channels, 1..8.
REQ-002 DW, default 32: data word width per channel.
REQ-003 DEPTH, default 16: words per channel FIFO, power of two, at least 2.
REQ-004 AF_LVL, default 12: occupancy at or above which a channel's almost-full flag is set, 1..DEPTH.
REQ-005 CHW, derived: max(1, clog2(NCH)), the channel tag width.

Interface
REQ-006 clk_clk  in  1  single clock; all logic on its rising edge.
REQ-007 reset_reset  in  1  synchronous, active-high reset.
REQ-008 write_en_export  in  1  global acquisition enable; low means input words are discarded.
REQ-009 fifo_in_writedata  in  NCH*DW  channel c occupies bits [c*DW +: DW].
REQ-010 fifo_in_write  in  NCH  per-channel write strobe.
REQ-011 fifo_in_waitrequest  out  NCH  per-channel stall; high when that channel's FIFO is full.
REQ-012 out_data  out  CHW+DW  merged stream, {channel index, word}.
REQ-013 out_valid  out  1  out_data holds a valid word.
REQ-014 out_ready  in  1  downstream accepts the word when out_valid is also high.
REQ-015 ch_level  out  NCH*(clog2(DEPTH)+1)  registered per-channel occupancy, 0..DEPTH.
REQ-016 almost_full  out  NCH  high when ch_level[c] >= AF_LVL.

Function
REQ-017 Each channel is a circular FIFO with wrapping read/write pointers and a separate occupancy count, so the full and empty states are unambiguous.
REQ-018 fifo_in_waitrequest[c] depends only on the registered count (count == DEPTH) and never on fifo_in_write.
REQ-019 A word is stored when write[c] is high, waitrequest[c] is low and write_en_export is high.
REQ-020 When write_en_export is low and waitrequest[c] is low, a write is accepted and the word is discarded; pointers and count are unchanged.
REQ-021 A full FIFO accepts no write even if a pop occurs in the same cycle; waitrequest falls in the cycle after the pop.
REQ-022 A simultaneous push and pop on a non-full, non-empty channel leaves the count unchanged and advances both pointers.
REQ-023 The output stage is one register. It loads when empty, or when out_valid and out_ready are both high in the current cycle, which allows back-to-back words at one word per cycle.
REQ-024 Channels are selected by round-robin among non-empty FIFOs, starting at (last granted + 1) mod NCH. The last-granted pointer updates only on a load.
REQ-025 While out_valid is high and out_ready is low, out_data and out_valid are held stable and no FIFO is popped.
REQ-026 Latency: a word accepted in cycle k into an empty system appears with out_valid high in cycle k+2.
REQ-027 Per-channel word order is preserved. Words from different channels are interleaved by arbitration only.
REQ-028 ch_level and almost_full reflect the count register and update the cycle after a push or pop.

Reset
REQ-029 In any cycle where reset_reset is high, all pointers, counts and the round-robin pointer (to NCH-1, so channel 0 is granted first) are cleared.
REQ-030 Reset also sets out_valid to 0, out_data to 0, waitrequest to 0, ch_level to 0 and almost_full to 0, all in the cycle after reset is sampled.
REQ-031 Reset mid-operation discards all buffered and held words, with no partial output. Writes presented during reset are not stored.

Structure
REQ-032 Package adc_merge_pkg holds the CHW and level-width functions and a channel-tag typedef.
REQ-033 The sub-module adc_chan_fifo (one channel: buffer, pointers, count, full, empty and level) is instantiated NCH times.
REQ-034 The arbiter and output register live in adc_fifo_merge.

Verification
REQ-035 NCH=2, DEPTH=16: write 0xA0000001 on ch0 in cycle 5 with out_ready=1 -> out_valid high in cycle 7 with out_data={0,0xA0000001}, then low.
REQ-036 With out_ready=0, write 16 words on ch1 -> waitrequest[1] high after the 16th; ch_level[1]=16; almost_full[1] high from level 12. A 17th write stalls with no data loss.
REQ-037 Both channels preloaded with 4 words each and out_ready=1 -> output sequence ch0,ch1,ch0,ch1,... for 8 cycles with per-channel order intact.
REQ-038 write_en_export=0 with 5 writes on ch0 -> waitrequest stays 0, ch_level[0] stays 0, out_valid stays 0.
REQ-039 Toggle out_ready as 1,0,0,1 during streaming -> out_data is stable while stalled; no word is dropped or duplicated across 20 words.
REQ-040 Assert reset for 1 cycle with 6 words buffered and out_valid high -> next cycle out_valid=0, ch_level=0, and the first post-reset write takes the k+2 latency.
